// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit instruction word.
// Used by both the instruction encoder/loader and the control decoder.
package cpu_isa_pkg;

    localparam logic [3:0] OP_MOV_RM = 4'd0;
    localparam logic [3:0] OP_MOV_MR = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_MOVI   = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_JMPZ   = 4'd5;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int RC_MSB  = 3;
    localparam int RC_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
        logic [7:0] imm;
    } instr_fields_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_MOV_RM, OP_MOV_MR, OP_ADD, OP_MOVI, OP_SUB, OP_JMPZ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Register-form ops carry rb/rc in the low byte; every other op carries imm there.
    function automatic logic [15:0] encode_instr(input instr_fields_t f);
        logic [15:0] w;
        w = '0;
        w[OP_MSB:OP_LSB] = f.op;
        w[RA_MSB:RA_LSB] = f.ra;
        if (f.op == OP_ADD || f.op == OP_SUB) begin
            w[RB_MSB:RB_LSB] = f.rb;
            w[RC_MSB:RC_LSB] = f.rc;
        end else begin
            w[IMM_MSB:IMM_LSB] = f.imm;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Bundle stream, instruction-memory write port and status of the encoder/loader.
// The master side is the program source / memory model, the slave side is the loader.
interface instr_encoder_loader_if #(
    parameter int AW = 8
) ();
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [3:0]    in_ra;
    logic [3:0]    in_rb;
    logic [3:0]    in_rc;
    logic [7:0]    in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          imem_ready;
    logic          busy;
    logic          done;
    logic          err_illegal;
    logic          err_overflow;
    logic [AW:0]   word_count;

    modport master (
        output start, base_addr, in_valid, in_op, in_ra, in_rb, in_rc, in_imm, in_last,
               imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal,
               err_overflow, word_count
    );

    modport slave (
        input  start, base_addr, in_valid, in_op, in_ra, in_rb, in_rc, in_imm, in_last,
               imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal,
               err_overflow, word_count
    );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with full/empty flags and a single-cycle flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Packs instruction field bundles into 16-bit words, buffers them and writes them
// sequentially into instruction memory starting from a programmable base address.
module instr_encoder_loader
    import cpu_isa_pkg::*;
#(
    parameter int AW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_encoder_loader_if.slave bus
);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   COUNT_ONE = (AW + 1)'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic          last_seen_q, last_seen_d;
    logic          err_illegal_q, err_illegal_d;
    logic          err_overflow_q, err_overflow_d;

    instr_fields_t fields;
    logic [15:0]   packed_word;
    logic [15:0]   fifo_head;
    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop, fifo_flush;
    logic          in_ready_w, write_en, accept, op_legal, at_top;

    assign fields = '{op: bus.in_op, ra: bus.in_ra, rb: bus.in_rb, rc: bus.in_rc,
                      imm: bus.in_imm};
    assign packed_word = encode_instr(fields);
    assign op_legal    = is_legal_op(bus.in_op);

    // Both strobes are masked during reset so nothing moves in the reset cycle.
    assign in_ready_w = !rst && (state_q == ST_LOAD) && !fifo_full && !last_seen_q;
    assign accept     = bus.in_valid && in_ready_w;
    assign fifo_push  = accept && op_legal;
    assign write_en   = !rst && !fifo_empty && !err_overflow_q &&
                        (state_q == ST_LOAD || state_q == ST_DRAIN);
    assign fifo_pop   = write_en && bus.imem_ready;
    assign at_top     = (wr_addr_q == '1);
    assign fifo_flush = fifo_pop && at_top;

    instr_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (packed_word),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        word_count_d   = word_count_q;
        last_seen_d    = last_seen_q;
        err_illegal_d  = err_illegal_q;
        err_overflow_d = err_overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d        = ST_LOAD;
                    wr_addr_d      = bus.base_addr;
                    word_count_d   = '0;
                    last_seen_d    = 1'b0;
                    err_illegal_d  = 1'b0;
                    err_overflow_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept && bus.in_last) begin
                    last_seen_d = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && !op_legal) err_illegal_d = 1'b1;

        // Completing the write to the top address ends the load early, overriding LOAD/DRAIN.
        if (fifo_pop) begin
            wr_addr_d    = wr_addr_q + ADDR_ONE;
            word_count_d = word_count_q + COUNT_ONE;
            if (at_top) begin
                err_overflow_d = 1'b1;
                state_d        = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_addr_q      <= '0;
            word_count_q   <= '0;
            last_seen_q    <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            word_count_q   <= word_count_d;
            last_seen_q    <= last_seen_d;
            err_illegal_q  <= err_illegal_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.imem_we      = write_en;
    assign bus.imem_addr    = wr_addr_q;
    assign bus.imem_wdata   = fifo_empty ? 16'h0000 : fifo_head;
    assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.err_illegal  = err_illegal_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.word_count   = word_count_q;
endmodule
